// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state/owner encodings, command record and default
// address window for the DMEM arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  // Default DMEM window in the MIPS data space
  localparam logic [31:0] DMEM_BASE_ADDR   = 32'h1001_0000;
  localparam logic [31:0] DMEM_DEPTH_BYTES = 32'h0000_0800;

  // One latched DMEM command
  typedef struct packed {
    logic        we;
    logic [2:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational winner selection between the CPU and DMA
// requesters. Build option DMEM_ARB_RR_EN switches ties from fixed CPU
// priority to round-robin against the previous grant owner.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic   cpu_req,
  input  logic   dma_req,
  input  owner_t last_owner,
  output logic   grant,
  output owner_t winner
);

  // Pick a winner whenever at least one port is requesting
  always_comb begin
    grant  = cpu_req | dma_req;
    winner = OWN_CPU;
`ifdef DMEM_ARB_RR_EN
    if (cpu_req && dma_req) begin
      winner = (last_owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
    end else if (dma_req) begin
      winner = OWN_DMA;
    end
`else
    if (!cpu_req && dma_req) begin
      winner = OWN_DMA;
    end
`endif
  end

`ifndef DMEM_ARB_RR_EN
  // Fixed priority has no use for the previous owner
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one DMEM between the CPU data port and a DMA/debug
// port. Each grant runs IDLE -> ACCESS -> RESP: the command is latched in
// IDLE, DMEM is driven in ACCESS, and the owner gets a one-cycle ack in RESP.
// Optional build macro DMEM_ARB_RR_EN selects round-robin tie-breaking.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
  parameter logic [31:0] DEPTH_BYTES = DMEM_DEPTH_BYTES
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_select,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [2:0]  dma_select,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic        dm_cs,
  output logic        dm_w,
  output logic        dm_r,
  output logic [2:0]  dm_select,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  // True when addr falls in [BASE_ADDR, BASE_ADDR+DEPTH_BYTES); addresses
  // below the base never wrap into the window.
  function automatic logic addr_in_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && (off < DEPTH_BYTES);
  endfunction

  state_t      state;
  owner_t      owner_p0;
  owner_t      last_owner;
  owner_t      winner;
  logic        grant;
  logic        hit_p0;
  cmd_t        cmd_p0;
  cmd_t        cpu_cmd;
  cmd_t        dma_cmd;
  cmd_t        win_cmd;
  logic [31:0] rdata_q;

  assign cpu_cmd = '{we: cpu_we, sel: cpu_select, addr: cpu_addr, wdata: cpu_wdata};
  assign dma_cmd = '{we: dma_we, sel: dma_select, addr: dma_addr, wdata: dma_wdata};
  assign win_cmd = (winner == OWN_DMA) ? dma_cmd : cpu_cmd;

  dmem_arb_pick u_pick (
    .cpu_req    (cpu_req),
    .dma_req    (dma_req),
    .last_owner (last_owner),
    .grant      (grant),
    .winner     (winner)
  );

`ifdef DMEM_ARB_RR_EN
  // Remember who owned the latest grant; resets to DMA so the CPU wins the first tie
  always_ff @(posedge clk_in) begin
    if (reset) begin
      last_owner <= OWN_DMA;
    end else if (state == IDLE && grant) begin
      last_owner <= winner;
    end
  end
`else
  assign last_owner = OWN_DMA;
`endif

  // ---- stage p0: command register, loaded on each grant ----
  // Latch the winning command; qualified by state so it needs no reset
  always_ff @(posedge clk_in) begin
    if (state == IDLE && grant) begin
      cmd_p0 <= win_cmd;
    end
  end

  // Sequencer: grant in IDLE, capture read data in ACCESS, ack in RESP
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state    <= IDLE;
      owner_p0 <= OWN_CPU;
      hit_p0   <= 1'b0;
      rdata_q  <= '0;
      cpu_ack  <= 1'b0;
      dma_ack  <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant) begin
            owner_p0 <= winner;
            hit_p0   <= addr_in_range(win_cmd.addr);
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          rdata_q <= (hit_p0 && !cmd_p0.we) ? dm_rdata : '0;
          cpu_ack <= (owner_p0 == OWN_CPU);
          dma_ack <= (owner_p0 == OWN_DMA);
          state   <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ---- stage p1: DMEM drive during ACCESS, from registered state only ----
  // Drive DMEM only for an in-range access; everything is zero otherwise
  always_comb begin
    dm_cs     = 1'b0;
    dm_w      = 1'b0;
    dm_r      = 1'b0;
    dm_select = '0;
    dm_addr   = '0;
    dm_wdata  = '0;
    if (state == ACCESS && hit_p0) begin
      dm_cs     = 1'b1;
      dm_w      = cmd_p0.we;
      dm_r      = ~cmd_p0.we;
      dm_select = cmd_p0.sel;
      dm_addr   = cmd_p0.addr - BASE_ADDR;
      dm_wdata  = cmd_p0.wdata;
    end
  end

  // ---- stage p2: response; read data only visible alongside the ack ----
  assign cpu_rdata = cpu_ack ? rdata_q : '0;
  assign dma_rdata = dma_ack ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed stimulus for dmem_arbiter,
// checked every cycle against a transaction-level reference model with a
// golden copy of DMEM. Honors DMEM_ARB_RR_EN for the tie-break rule.
module tb_dmem_arbiter;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam logic [31:0] DEPTH = 32'h0000_0800;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [2:0]  cpu_select = '0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [2:0]  dma_select = '0;
  logic [31:0] dma_addr = '0, dma_wdata = '0;
  logic        dma_ack;
  logic [31:0] dma_rdata;
  logic        dm_cs, dm_w, dm_r;
  logic [2:0]  dm_select;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;

  logic [31:0] mem  [0:511];
  logic [31:0] gold [0:511];
  logic        init_mem = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int          cyc = 0;
  int          free_at = 0;
  bit          last_dma = 1'b1;
  bit          pend_v = 1'b0;
  bit          pend_own = 1'b0;
  logic [31:0] pend_rd = '0;

  always #5 clk_in = ~clk_in;

  dmem_arbiter dut (
    .clk_in(clk_in), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_select(cpu_select),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_select(dma_select),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .dm_cs(dm_cs), .dm_w(dm_w), .dm_r(dm_r), .dm_select(dm_select),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  function automatic logic [31:0] pat(input int i);
    return 32'hA500_0000 ^ (i * 32'h0001_0203);
  endfunction

  // DMEM model: word-wide, combinational read, write on the clock edge
  assign dm_rdata = mem[dm_addr[10:2]];
  always @(posedge clk_in) begin
    if (init_mem) begin
      for (int i = 0; i < 512; i++) mem[i] <= pat(i);
    end else if (dm_cs && dm_w) begin
      mem[dm_addr[10:2]] <= dm_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a);
    longint unsigned x, lo, hi;
    x  = a;
    lo = BASE;
    hi = lo + DEPTH;
    return (x >= lo) && (x < hi);
  endfunction

  // One clock: advance the reference model on the edge, then compare outputs
  task automatic step();
    bit          rst_s, creq, dreq, win, we, acc_v, acc_in;
    bit          e_cack, e_dack;
    logic [31:0] e_crd, e_drd, a, d, off;
    logic [2:0]  sel;
    rst_s = reset; creq = cpu_req; dreq = dma_req;
    @(posedge clk_in);
    #1;
    cyc++;
    e_cack = 0; e_dack = 0; e_crd = '0; e_drd = '0;
    acc_v = 0; acc_in = 0; we = 0; a = '0; d = '0; sel = '0; off = '0;
    if (rst_s) begin
      free_at  = cyc + 1;
      last_dma = 1'b1;
      pend_v   = 1'b0;
    end else begin
      if (pend_v) begin
        if (pend_own) begin e_dack = 1; e_drd = pend_rd; end
        else begin e_cack = 1; e_crd = pend_rd; end
      end
      pend_v = 1'b0;
      if (cyc >= free_at && (creq || dreq)) begin
        if (creq && dreq) begin
`ifdef DMEM_ARB_RR_EN
          win = !last_dma;
`else
          win = 1'b0;
`endif
        end else begin
          win = dreq;
        end
        last_dma = win;
        we  = win ? dma_we : cpu_we;
        sel = win ? dma_select : cpu_select;
        a   = win ? dma_addr : cpu_addr;
        d   = win ? dma_wdata : cpu_wdata;
        acc_v  = 1;
        acc_in = in_window(a);
        off    = a - BASE;
        pend_v   = 1'b1;
        pend_own = win;
        pend_rd  = (acc_in && !we) ? gold[off[10:2]] : '0;
        if (acc_in && we) gold[off[10:2]] = d;
        free_at = cyc + 3;
      end
    end
    chk("cpu_ack", cpu_ack, e_cack);
    chk("dma_ack", dma_ack, e_dack);
    chk("cpu_rdata", cpu_rdata, e_crd);
    chk("dma_rdata", dma_rdata, e_drd);
    chk("dm_cs", dm_cs, acc_v && acc_in);
    chk("dm_w", dm_w, acc_v && acc_in && we);
    chk("dm_r", dm_r, acc_v && acc_in && !we);
    if (acc_v && acc_in) begin
      chk("dm_addr", dm_addr, off);
      chk("dm_select", dm_select, sel);
      chk("dm_wdata", dm_wdata, d);
    end else if (!acc_v) begin
      chk("dm_addr_idle", dm_addr, 32'h0);
    end
  endtask

  task automatic set_port(input bit port, input bit req, input bit we,
                          input logic [31:0] a, input logic [31:0] d);
    if (port) begin
      dma_req = req; dma_we = we; dma_select = 3'b010; dma_addr = a; dma_wdata = d;
    end else begin
      cpu_req = req; cpu_we = we; cpu_select = 3'b010; cpu_addr = a; cpu_wdata = d;
    end
  endtask

  // One complete access on a port, bounded wait for its ack
  task automatic xfer(input bit port, input bit we, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rd);
    bit done;
    done = 0;
    rd   = '0;
    set_port(port, 1'b1, we, a, d);
    for (int k = 0; k < 20 && !done; k++) begin
      step();
      if (port ? dma_ack : cpu_ack) begin
        done = 1;
        rd = port ? dma_rdata : cpu_rdata;
      end
    end
    set_port(port, 1'b0, 1'b0, '0, '0);
    chk("xfer_done", done, 1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic new_req(input bit port);
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0:       a = 32'h0FFF_FFFC;
      1:       a = 32'h1001_0800;
      2:       a = 32'h1001_07FC;
      3:       a = 32'h1001_07FF;
      4:       a = $urandom;
      default: a = BASE + ($urandom_range(0, 15) << 2);
    endcase
    if (port) begin
      dma_req = 1; dma_we = 1'($urandom_range(0, 1)); dma_select = 3'($urandom_range(0, 7));
      dma_addr = a; dma_wdata = $urandom;
    end else begin
      cpu_req = 1; cpu_we = 1'($urandom_range(0, 1)); cpu_select = 3'($urandom_range(0, 7));
      cpu_addr = a; cpu_wdata = $urandom;
    end
  endtask

  initial begin
    logic [31:0] rd;
    int          t [0:2];
    bit          own [0:2];
    bit          exp_own [0:2];
    int          n, c0, nbad_words;

    for (int i = 0; i < 512; i++) gold[i] = pat(i);

    // reset state
    reset = 1;
    idle(2);
    init_mem = 0;
    reset = 0;
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_dm_cs", dm_cs, 0);
    idle(2);

    // CPU write then read back through the window
    xfer(0, 1, 32'h1001_0004, 32'hDEAD_BEEF, rd);
    xfer(0, 0, 32'h1001_0004, 32'h0, rd);
    chk("cpu_rd_beef", rd, 32'hDEAD_BEEF);

    // top word of the window via DMA
    xfer(1, 1, 32'h1001_07FC, 32'h1234_5678, rd);
    xfer(1, 0, 32'h1001_07FC, 32'h0, rd);
    chk("dma_rd_top", rd, 32'h1234_5678);

    // out-of-range reads and writes are dropped
    xfer(1, 0, 32'h0FFF_FFFC, 32'h0, rd);
    chk("oor_low_rd", rd, 32'h0);
    xfer(1, 0, 32'h1001_0800, 32'h0, rd);
    chk("oor_high_rd", rd, 32'h0);
    xfer(1, 1, 32'h1001_0800, 32'hBAD0_BAD0, rd);
    xfer(0, 1, 32'h0FFF_FFFC, 32'hBAD1_BAD1, rd);
    chk("oor_word0", mem[0], gold[0]);
    chk("oor_word511", mem[511], 32'h1234_5678);

    // latency and back-to-back spacing with req held across ack
    idle(3);
    c0 = cyc;
    n  = 0;
    set_port(0, 1'b1, 1'b0, 32'h1001_0004, '0);
    for (int k = 0; k < 30 && n < 3; k++) begin
      step();
      if (cpu_ack) begin
        t[n] = cyc;
        n++;
        cpu_addr = BASE + (n << 2);
      end
    end
    set_port(0, 1'b0, 1'b0, '0, '0);
    chk("hold_count", n, 3);
    chk("latency", t[0] - c0, 2);
    chk("spacing1", t[1] - t[0], 3);
    chk("spacing2", t[2] - t[1], 3);

    // ties: three grants with both ports requesting throughout
    reset = 1;
    step();
    reset = 0;
    n = 0;
    set_port(0, 1'b1, 1'b0, 32'h1001_0008, '0);
    set_port(1, 1'b1, 1'b0, 32'h1001_000C, '0);
    for (int k = 0; k < 40 && n < 3; k++) begin
      step();
      if (cpu_ack && n < 3) begin own[n] = 0; n++; end
      if (dma_ack && n < 3) begin own[n] = 1; n++; end
    end
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
`ifdef DMEM_ARB_RR_EN
    exp_own[0] = 0; exp_own[1] = 1; exp_own[2] = 0;
`else
    exp_own[0] = 0; exp_own[1] = 0; exp_own[2] = 0;
`endif
    chk("tie_count", n, 3);
    for (int i = 0; i < 3; i++) chk($sformatf("tie_owner%0d", i), own[i], exp_own[i]);
    idle(4);

    // reset while a CPU write sits in ACCESS
    set_port(0, 1'b1, 1'b1, 32'h1001_0010, 32'h55AA_55AA);
    step();
    chk("mid_dm_w", dm_w, 1);
    reset = 1;
    step();
    reset = 0;
    set_port(0, 1'b0, 1'b0, '0, '0);
    chk("mid_no_ack", cpu_ack, 0);
    step();
    chk("mid_no_ack2", cpu_ack, 0);
    xfer(0, 0, 32'h1001_0010, 32'h0, rd);
    chk("mid_rd", rd, 32'h55AA_55AA);

    // randomized traffic from both ports
    for (int k = 0; k < 3000; k++) begin
      bit ca, da;
      step();
      ca = cpu_ack;
      da = dma_ack;
      if (ca) begin
        if ($urandom_range(0, 3) == 0) set_port(0, 1'b0, 1'b0, '0, '0);
        else new_req(0);
      end else if (!cpu_req && $urandom_range(0, 2) == 0) begin
        new_req(0);
      end
      if (da) begin
        if ($urandom_range(0, 2) == 0) set_port(1, 1'b0, 1'b0, '0, '0);
        else new_req(1);
      end else if (!dma_req && $urandom_range(0, 2) == 0) begin
        new_req(1);
      end
    end
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    idle(5);

    nbad_words = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== gold[i]) nbad_words++;
    chk("mem_final", nbad_words, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data memory (DMEM) between the CPU data port and a DMA/debug requester. It sits between `cpu`/DMA and `DMEM` in `sccomp_dataflow`. It picks one requester, translates the MIPS data address to a DMEM offset, and sequences one DMEM access per grant. It returns read data with a one-cycle acknowledge.

## Interface
Parameters:
- BASE_ADDR, 32'h10010000, byte address that maps to DMEM offset 0
- DEPTH_BYTES, 32'h00000800, DMEM size in bytes; valid range is [BASE_ADDR, BASE_ADDR+DEPTH_BYTES)

Ports:
- clk_in  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_select  in  3  access-width code, passed to DMEM unchanged
- cpu_addr  in  32  byte address, MIPS data space
- cpu_wdata  in  32  write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  32  read data, valid while cpu_ack=1
- dma_req, dma_we, dma_select, dma_addr, dma_wdata  in  1/1/3/32/32  same meaning as the cpu_ inputs
- dma_ack  out  1  one-cycle completion pulse
- dma_rdata  out  32  read data, valid while dma_ack=1
- dm_cs  out  1  DMEM enable
- dm_w  out  1  DMEM write strobe
- dm_r  out  1  DMEM read strobe
- dm_select  out  3  DMEM width code
- dm_addr  out  32  DMEM offset (addr − BASE_ADDR)
- dm_wdata  out  32  DMEM write data
- dm_rdata  in  32  DMEM combinational read data

## Operation
- States:
  - IDLE: sample requests.
  - ACCESS: drive DMEM.
  - RESP: pulse ack.
- IDLE:
  - If any req=1, latch the winner's we/select/addr/wdata into a command register, record the owner, go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - If the latched address is in range: dm_cs=1, dm_w=we, dm_r=~we, dm_addr = addr − BASE_ADDR (32-bit wrapping subtract), dm_select and dm_wdata from the command register.
  - On a read, capture dm_rdata into rdata_q at the end of ACCESS.
  - If the address is out of range: all dm_* strobes stay 0, rdata_q=0, and the access is silently dropped.
  - Always go to RESP.
- RESP:
  - The owner's ack=1 and owner's rdata=rdata_q. The other port's ack=0.
  - Requests are ignored in RESP. Go to IDLE.
- Tie-break (both req=1 in IDLE): fixed CPU priority; see Configuration.
- A requester must drop req, or present a new request, in the cycle after ack. A req still high in IDLE is a new access.
- The non-owner's req is held pending; it is served on the next IDLE it wins.
- rdata outputs are 0 whenever the corresponding ack=0.
- dm_* outputs are 0 in IDLE and RESP.

## Timing
- Reset values: state=IDLE; cpu_ack=dma_ack=0; cpu_rdata=dma_rdata=0; all dm_* = 0; rdata_q=0.
  - With the Configuration macro, the round-robin pointer resets to DMA-last, so the CPU wins the first tie.
- Latency: req sampled at edge N (IDLE) → ACCESS in cycle N+1 → ack in cycle N+2.
- Throughput: one access per 3 cycles.
- A DMEM write commits on the edge ending ACCESS.
- Reset mid-operation:
  - A reset asserted during ACCESS still lets that edge's DMEM write commit, because dm_w is driven from registered state.
  - No ack is issued for the aborted access, and the next state is IDLE.
  - A reset during RESP cancels the ack from the following cycle.
- Address exactly BASE_ADDR+DEPTH_BYTES−1 is in range. BASE_ADDR+DEPTH_BYTES is out of range. Addresses below BASE_ADDR are out of range (no wrap acceptance).

## Configuration
- DMEM_ARB_RR_EN defined: round-robin tie-break.
  - A last-owner register updates on each grant.
  - On a tie, the port that did not own the previous grant wins.
- Undefined: the CPU always wins ties. A continuously requesting CPU may starve the DMA; this is acceptable.

## Structure
- Package dmem_arb_pkg:
  - state enum (IDLE, ACCESS, RESP)
  - owner encoding (OWN_CPU, OWN_DMA)
  - default BASE_ADDR and DEPTH_BYTES constants
- Sub-module dmem_arb_pick: combinational winner selection from cpu_req, dma_req and the last owner (round-robin path under the macro).

## Test plan
- CPU write 0xDEADBEEF to 0x10010004, select=word; then CPU read 0x10010004 → dm_addr=0x4; cpu_ack in cycle N+2; cpu_rdata=0xDEADBEEF.
- Both req=1 on the same edge, three times back-to-back:
  - Without the macro → grants CPU, CPU, CPU.
  - With DMEM_ARB_RR_EN → CPU, DMA, CPU.
- DMA read at 0x0FFFFFFC and at 0x10010800 → dm_cs stays 0; dma_ack pulses with dma_rdata=0; DMEM contents unchanged.
- DMA read at 0x100107FC after a write of 0x12345678 there → dm_addr=0x7FC; data returned.
- Reset asserted in ACCESS of a CPU write of 0x55AA55AA to 0x10010010 → no cpu_ack; next state IDLE; a later read returns 0x55AA55AA.
- CPU holds req across ack → second access starts in the IDLE after RESP; ack spacing is exactly 3 cycles.
